// File: rtl/exhaustive_sweep_capture_if.sv
// Purpose: record stream carrying one (pattern, response) pair per transfer.
// Latency: none; this is wiring only.
// Backpressure: the master holds the record stable while rec_valid=1 and rec_ready=0.
interface exhaustive_sweep_capture_if #(
   parameter int IN_W  = 4,
   parameter int OUT_W = 1
);
   logic             rec_valid;
   logic             rec_ready;
   logic [IN_W-1:0]  rec_pattern;
   logic [OUT_W-1:0] rec_response;

   modport master (
      output rec_valid,
      output rec_pattern,
      output rec_response,
      input  rec_ready
   );

   modport slave (
      input  rec_valid,
      input  rec_pattern,
      input  rec_response,
      output rec_ready
   );
endinterface

// File: rtl/exhaustive_sweep_capture.sv
// Purpose: sweep all 2^IN_W DUT input patterns, stream (pattern, response) records, fold responses into a MISR.
// Latency: SETTLE+1 cycles per pattern with rec_ready high; done pulses 2^IN_W*(SETTLE+1) edges after start.
// Backpressure: record and dut_in hold in HOLD until rec_ready; abort or reset drops the sweep.
module exhaustive_sweep_capture #(
   parameter int               IN_W   = 4,
   parameter int               OUT_W  = 1,
   parameter int               SETTLE = 1,
   parameter int               SIG_W  = 16,
   parameter logic [SIG_W-1:0] POLY   = 16'h1021
) (
   input  logic                      CK,
   input  logic                      reset,
   input  logic                      start,
   input  logic                      abort,
   input  logic [1:0]                mode,
   output logic [IN_W-1:0]           dut_in,
   input  logic [OUT_W-1:0]          dut_out,
   exhaustive_sweep_capture_if.master rec,
   output logic                      busy,
   output logic                      done,
   output logic [SIG_W-1:0]          signature
);

   localparam int              CNT_W       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
   localparam logic [IN_W-1:0]  LAST_IDX    = {IN_W{1'b1}};

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_APPLY = 2'd1;
   localparam logic [1:0] ST_HOLD  = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   logic [1:0]       state;
   logic [1:0]       mode_q;
   logic [IN_W-1:0]  index;
   logic [IN_W-1:0]  index_inc;
   logic [CNT_W-1:0] settle_cnt;
   logic [SIG_W-1:0] resp_ext;
   logic [SIG_W-1:0] misr_next;

   // Index-to-pattern mapping; mode 3 is reserved and falls back to ascending.
   function automatic logic [IN_W-1:0] pattern_of(input logic [1:0] md, input logic [IN_W-1:0] i);
      logic [IN_W-1:0] p;
      case (md)
         2'd1:    p = i ^ (i >> 1);
         2'd2:    p = ~i;
         default: p = i;
      endcase
      return p;
   endfunction

   // Next MISR value folding in the response being sampled this edge.
   always_comb begin
      resp_ext              = '0;
      resp_ext[OUT_W-1:0]   = dut_out;
      misr_next             = {signature[SIG_W-2:0], 1'b0} ^ (signature[SIG_W-1] ? POLY : '0) ^ resp_ext;
      index_inc             = index + IN_W'(1);
   end

   // Sweep sequencer: apply, settle, capture, hand off, advance.
   always_ff @(posedge CK) begin
      if (!reset) begin
         state            <= ST_IDLE;
         mode_q           <= 2'd0;
         index            <= '0;
         settle_cnt       <= '0;
         dut_in           <= '0;
         rec.rec_valid    <= 1'b0;
         rec.rec_pattern  <= '0;
         rec.rec_response <= '0;
         busy             <= 1'b0;
         done             <= 1'b0;
         signature        <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  mode_q     <= mode;
                  index      <= '0;
                  signature  <= '0;
                  dut_in     <= pattern_of(mode, {IN_W{1'b0}});
                  busy       <= 1'b1;
                  settle_cnt <= '0;
                  state      <= ST_APPLY;
               end
            end
            ST_APPLY: begin
               if (abort) begin
                  rec.rec_valid <= 1'b0;
                  busy          <= 1'b0;
                  state         <= ST_IDLE;
               end else if (settle_cnt == SETTLE_LAST) begin
                  rec.rec_response <= dut_out;
                  rec.rec_pattern  <= dut_in;
                  rec.rec_valid    <= 1'b1;
                  signature        <= misr_next;
                  state            <= ST_HOLD;
               end else begin
                  settle_cnt <= settle_cnt + CNT_W'(1);
               end
            end
            ST_HOLD: begin
               if (abort) begin
                  // A record handshaking on this edge simply counts as taken.
                  rec.rec_valid <= 1'b0;
                  busy          <= 1'b0;
                  state         <= ST_IDLE;
               end else if (rec.rec_ready) begin
                  rec.rec_valid <= 1'b0;
                  if (index == LAST_IDX) begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= ST_DONE;
                  end else begin
                     index      <= index_inc;
                     dut_in     <= pattern_of(mode_q, index_inc);
                     settle_cnt <= '0;
                     state      <= ST_APPLY;
                  end
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_exhaustive_sweep_capture.sv
// Bench for exhaustive_sweep_capture: directed sweeps with randomized DUT truth tables.
// A second instance with SETTLE=3 sees a delayed-response DUT to pin down sampling time.
// Expected records and signatures come from an arithmetic reference model.
module tb_exhaustive_sweep_capture;

   localparam logic [15:0] POLY = 16'h1021;

   logic        CK      = 1'b0;
   logic        reset   = 1'b0;
   logic        start   = 1'b0;
   logic        abort   = 1'b0;
   logic [1:0]  mode    = 2'd0;
   logic [3:0]  dut_in;
   logic [0:0]  dut_out;
   logic        busy;
   logic        done;
   logic [15:0] signature;

   logic        start_b = 1'b0;
   logic        abort_b = 1'b0;
   logic [1:0]  mode_b  = 2'd0;
   logic [3:0]  dut_in_b;
   logic [0:0]  dut_out_b;
   logic        busy_b;
   logic        done_b;
   logic [15:0] signature_b;
   logic [3:0]  d1 = 4'd0;
   logic [3:0]  d2 = 4'd0;

   exhaustive_sweep_capture_if #(.IN_W(4), .OUT_W(1)) rec_a ();
   exhaustive_sweep_capture_if #(.IN_W(4), .OUT_W(1)) rec_b ();

   exhaustive_sweep_capture #(.IN_W(4), .OUT_W(1), .SETTLE(1), .SIG_W(16), .POLY(POLY)) dut_a (
      .CK(CK), .reset(reset), .start(start), .abort(abort), .mode(mode),
      .dut_in(dut_in), .dut_out(dut_out), .rec(rec_a),
      .busy(busy), .done(done), .signature(signature)
   );

   exhaustive_sweep_capture #(.IN_W(4), .OUT_W(1), .SETTLE(3), .SIG_W(16), .POLY(POLY)) dut_b (
      .CK(CK), .reset(reset), .start(start_b), .abort(abort_b), .mode(mode_b),
      .dut_in(dut_in_b), .dut_out(dut_out_b), .rec(rec_b),
      .busy(busy_b), .done(done_b), .signature(signature_b)
   );

   always #5 CK = ~CK;

   int          dut_fn   = 0;
   logic [15:0] rand_tab = 16'd0;
   int          n_pass   = 0;
   int          n_fail   = 0;
   int          n_total  = 0;
   int          cyc      = 0;
   int          rk       = 0;
   logic [1:0]  mode_lat = 2'd0;
   logic [15:0] msig     = 16'd0;

   // Device under sweep: 0 AND, 1 constant 0, 2 input bit 0, otherwise random truth table.
   function automatic logic ref_dut(input int fn, input logic [3:0] p);
      case (fn)
         0:       return &p;
         1:       return 1'b0;
         2:       return p[0];
         default: return rand_tab[p];
      endcase
   endfunction

   assign dut_out[0] = ref_dut(dut_fn, dut_in);

   // Slow device: its output only reflects an input after two more edges.
   always @(posedge CK) begin
      d1 <= dut_in_b;
      d2 <= d1;
   end
   assign dut_out_b[0] = ^d2;

   function automatic logic [3:0] exp_pat(input logic [1:0] md, input int i);
      logic [3:0] v;
      v = 4'(i);
      case (md)
         2'd1:    return v ^ (v >> 1);
         2'd2:    return 4'(15 - i);
         default: return v;
      endcase
   endfunction

   function automatic logic [15:0] misr(input logic [15:0] s, input logic r);
      int t;
      t = (int'(s) * 2) % 65536;
      if (int'(s) >= 32768) t = t ^ int'(POLY);
      return 16'(t) ^ {15'd0, r};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CK);
      #1;
      cyc++;
   endtask

   task automatic begin_sweep(input logic [1:0] md);
      mode  = md;
      start = 1'b1;
      tick();
      start = 1'b0;
      cyc   = 0;
      mode  = (md == 2'd1) ? 2'd2 : 2'd1;
      mode_lat = (md == 2'd3) ? 2'd0 : md;
      rk    = 0;
      msig  = 16'd0;
      chk("busy_after_start", 32'(busy), 1);
   endtask

   task automatic consume(input int n, input int stall_k, input int stall_len);
      int budget = 0;
      logic [3:0] p;
      logic       r;
      while (n > 0 && budget < 400) begin
         rec_a.rec_ready = 1'b1;
         if (rec_a.rec_valid) begin
            p = exp_pat(mode_lat, rk);
            r = ref_dut(dut_fn, p);
            if (rk == stall_k) begin
               rec_a.rec_ready = 1'b0;
               for (int s = 0; s < stall_len; s++) begin
                  tick();
                  budget++;
                  chk("stall_valid", 32'(rec_a.rec_valid), 1);
                  chk("stall_pattern", 32'(rec_a.rec_pattern), 32'(p));
                  chk("stall_dut_in", 32'(dut_in), 32'(p));
                  chk("stall_signature", 32'(signature), 32'(misr(msig, r)));
               end
               rec_a.rec_ready = 1'b1;
            end
            chk("rec_pattern", 32'(rec_a.rec_pattern), 32'(p));
            chk("rec_response", 32'(rec_a.rec_response), 32'(r));
            msig = misr(msig, r);
            rk++;
            n--;
         end
         tick();
         budget++;
      end
      chk("consume_timeout", n, 0);
   endtask

   task automatic wait_valid();
      int budget = 0;
      while (!rec_a.rec_valid && budget < 50) begin
         tick();
         budget++;
      end
      chk("wait_valid_timeout", 32'(rec_a.rec_valid), 1);
   endtask

   task automatic check_cleared(input string tag);
      chk({tag, "_dut_in"}, 32'(dut_in), 0);
      chk({tag, "_rec_valid"}, 32'(rec_a.rec_valid), 0);
      chk({tag, "_rec_pattern"}, 32'(rec_a.rec_pattern), 0);
      chk({tag, "_rec_response"}, 32'(rec_a.rec_response), 0);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_done"}, 32'(done), 0);
      chk({tag, "_signature"}, 32'(signature), 0);
   endtask

   task automatic check_done(input string tag, input int exp_cyc);
      chk({tag, "_done_cycle"}, cyc, exp_cyc);
      chk({tag, "_done"}, 32'(done), 1);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_signature"}, 32'(signature), 32'(msig));
   endtask

   initial begin
      int quiet_bad;
      int recs;
      int done_at;
      logic [15:0] sig_b;
      logic [3:0]  pb;

      rand_tab        = 16'($urandom);
      rec_a.rec_ready = 1'b0;
      rec_b.rec_ready = 1'b1;

      // Reset state
      reset = 1'b0;
      tick();
      tick();
      check_cleared("reset");
      reset = 1'b1;
      tick();

      // Ascending sweep with an AND device; final values must persist after done
      dut_fn = 0;
      begin_sweep(2'd0);
      consume(16, -1, 0);
      check_done("asc", 32);
      tick();
      chk("asc_done_one_cycle", 32'(done), 0);
      chk("asc_final_dut_in", 32'(dut_in), 32'hF);
      tick();
      tick();
      chk("asc_signature_hold", 32'(signature), 32'(msig));

      // Gray order with a random truth table
      dut_fn = 3;
      begin_sweep(2'd1);
      consume(16, -1, 0);
      check_done("gray", 32);
      tick();

      // Descending order with dut_in[0] as the response
      dut_fn = 2;
      begin_sweep(2'd2);
      consume(16, -1, 0);
      check_done("desc", 32);
      chk("desc_final_dut_in", 32'(dut_in), 0);
      tick();

      // Reserved mode behaves as ascending; five-cycle stall on the fourth record
      dut_fn = 0;
      begin_sweep(2'd3);
      consume(16, 3, 5);
      check_done("stall", 37);
      tick();

      // Constant-zero device leaves the signature at zero
      dut_fn = 1;
      begin_sweep(2'd0);
      consume(16, -1, 0);
      chk("zero_signature", 32'(signature), 0);
      check_done("zero", 32);
      tick();

      // start while busy is ignored; reset during the 8th record clears everything
      dut_fn = 2;
      begin_sweep(2'd0);
      consume(2, -1, 0);
      rec_a.rec_ready = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("restart_ignored_busy", 32'(busy), 1);
      consume(5, -1, 0);
      rec_a.rec_ready = 1'b0;
      wait_valid();
      chk("eighth_pattern", 32'(rec_a.rec_pattern), 32'(exp_pat(2'd0, 7)));
      reset = 1'b0;
      tick();
      check_cleared("midreset");
      reset = 1'b1;
      rec_a.rec_ready = 1'b1;
      quiet_bad = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (rec_a.rec_valid || busy || done) quiet_bad++;
      end
      chk("midreset_quiet", quiet_bad, 0);
      begin_sweep(2'd0);
      consume(16, -1, 0);
      check_done("after_reset", 32);
      tick();

      // Abort while the 6th record handshakes: it counts, sweep stops, no done
      dut_fn = 3;
      begin_sweep(2'd0);
      consume(5, -1, 0);
      rec_a.rec_ready = 1'b1;
      wait_valid();
      msig  = misr(msig, ref_dut(dut_fn, exp_pat(2'd0, 5)));
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_busy", 32'(busy), 0);
      chk("abort_rec_valid", 32'(rec_a.rec_valid), 0);
      chk("abort_done", 32'(done), 0);
      chk("abort_signature", 32'(signature), 32'(msig));
      quiet_bad = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (done || rec_a.rec_valid || busy || signature !== msig) quiet_bad++;
      end
      chk("abort_quiet", quiet_bad, 0);
      begin_sweep(2'd0);
      consume(16, -1, 0);
      check_done("after_abort", 32);
      tick();

      // SETTLE=3 instance: responses must reflect the current pattern three edges on
      start_b = 1'b1;
      tick();
      start_b = 1'b0;
      cyc     = 0;
      recs    = 0;
      done_at = -1;
      sig_b   = 16'd0;
      for (int e = 0; e < 200 && done_at < 0; e++) begin
         if (rec_b.rec_valid) begin
            pb = exp_pat(2'd0, recs);
            chk("settle3_pattern", 32'(rec_b.rec_pattern), 32'(pb));
            chk("settle3_response", 32'(rec_b.rec_response), 32'(^pb));
            sig_b = misr(sig_b, ^pb);
            recs++;
         end
         tick();
         if (done_b) done_at = cyc;
      end
      chk("settle3_records", recs, 16);
      chk("settle3_done_cycle", done_at, 64);
      chk("settle3_signature", 32'(signature_b), 32'(sig_b));

      if (n_fail > 0) $display("%0d comparisons did not match", n_fail);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/exhaustive_sweep_capture.md
Name: exhaustive_sweep_capture

Overview:
- Hardware successor to the fixed 4-bit exhaustive stimulus benches used in trojan-detection data collection.
- Sweeps every input pattern of an IN_W-bit DUT in a selectable order and waits a programmable settle time before sampling the DUT output.
- Streams each (pattern, response) record out over a valid/ready interface and accumulates a MISR signature for golden-vs-suspect comparison.

Parameters:
- IN_W, 4: DUT input width; sweep covers 2^IN_W patterns; range 1..16.
- OUT_W, 1: DUT output width; must be ≤ SIG_W.
- SETTLE, 1: clock edges between applying a pattern and sampling the response; minimum 1.
- SIG_W, 16: signature width.
- POLY, 16'h1021: MISR feedback polynomial, SIG_W bits.

Ports:
- CK  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  begin a sweep; sampled only in IDLE.
- abort  in  1  stop a sweep in progress.
- mode  in  2  sweep order: 0 ascending binary, 1 Gray, 2 descending binary, 3 reserved (treated as 0).
- dut_in  out  IN_W  pattern driven to the DUT.
- dut_out  in  OUT_W  DUT response.
- rec_valid  out  1  record available.
- rec_ready  in  1  consumer accepts record.
- rec_pattern  out  IN_W  pattern of the current record.
- rec_response  out  OUT_W  sampled response of the current record.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse when a sweep completes.
- signature  out  SIG_W  MISR value.

Behaviour:
- Reset: all registers update at a CK edge when reset=0. dut_in=0, rec_valid=0, rec_pattern=0, rec_response=0, busy=0, done=0, signature=0, index=0, state=IDLE.
- Reset mid-sweep has the same effect: the sweep is abandoned and nothing is emitted afterward.
- FSM states are IDLE, APPLY, HOLD, DONE.
- Pattern mapping, with index i of IN_W bits:
  - mode 0: pattern = i.
  - mode 1: pattern = i ^ (i>>1).
  - mode 2: pattern = ~i.
  - Mode is latched at the start edge; later mode changes have no effect until the next sweep.
- IDLE:
  - On an edge with start=1: index=0, signature=0, dut_in=pattern(0), busy=1, settle counter=0, go to APPLY.
  - start is ignored in all other states.
- APPLY:
  - The settle counter increments each edge.
  - On the SETTLE-th edge after dut_in changed: rec_response=dut_out, rec_pattern=dut_in, rec_valid=1, go to HOLD.
  - On that same edge, signature is updated with the just-sampled dut_out: signature = ({sig[SIG_W-2:0],0} ^ (sig[SIG_W-1] ? POLY : 0)) ^ zero_extend(dut_out).
- HOLD:
  - rec_valid stays 1 and rec_pattern, rec_response and dut_in stay stable until an edge with rec_ready=1.
  - On acceptance, if index = 2^IN_W-1: rec_valid=0, go to DONE.
  - Otherwise: index++, dut_in=pattern(index), rec_valid=0, settle counter=0, go to APPLY.
- DONE: for one cycle done=1 and busy=0, then go to IDLE.
  - signature and dut_in hold their final values until the next start or reset.
- Latency with rec_ready held at 1: SETTLE+1 cycles per pattern. done is high in the cycle that begins 2^IN_W·(SETTLE+1) edges after the start edge.
- abort: on an edge with abort=1 in APPLY or HOLD, go to IDLE.
  - rec_valid=0, busy=0, done stays 0, signature is frozen.
  - A record that is handshaking on the same edge is considered accepted.
  - abort has priority over the HOLD transition; reset has priority over everything.
- rec_ready is ignored whenever rec_valid=0.
- index wrap: index never increments past 2^IN_W-1; the sweep terminates there.

Test Plan:
- Ascending sweep: IN_W=4, SETTLE=1, mode=0, rec_ready=1, DUT = AND of inputs → 16 records in order 0000..1111, response 1 only at 1111, done pulse in cycle 32 after start.
- Gray sweep: mode=1 → rec_pattern sequence 0000,0001,0011,0010,0110,0111,0101,0100,1100,…,1000; every consecutive pair differs in exactly one bit. Descending sweep: mode=2 → sequence 1111..0000.
- Backpressure and settle: rec_ready=0 for 5 cycles at the 4th record → rec_valid held 1, rec_pattern=0011 and dut_in=0011 stable, no further records or signature change. With SETTLE=3, each sample is taken 3 edges after the dut_in change.
- Signature: DUT constant 0 → signature 0x0000 at done. DUT = dut_in[0] → signature matches the bench MISR reference model.
- Reset and start-while-busy: reset=0 during the 8th record → all outputs zero at the next edge. start pulsed while busy is ignored. A new start after reset restarts from pattern 0000 with signature 0.
- Abort: abort at the 6th record → busy=0, no done pulse, signature frozen. A subsequent start gives a complete 16-record sweep.
